// File: rtl/mips_pkg.sv
// Shared definitions for the program loader and its neighbours.
//   - loader_state_e : loader FSM states
//   - AddrWidth      : instruction memory byte-address width
//   - WordWidth      : instruction word width
//   - CountWidth     : width of the word_count input
//   - MaxWords       : instruction memory depth in words
package mips_pkg;

    localparam int unsigned AddrWidth  = 8;
    localparam int unsigned WordWidth  = 32;
    localparam int unsigned CountWidth = 7;
    localparam int unsigned MaxWords   = 64;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/program_loader_if.sv
// Bundle of the loader's control, byte-stream and instruction-memory signals.
// Modports:
//   master : the host side (drives start/word_count/byte stream, observes the rest)
//   slave  : the loader (accepts the byte stream, drives memory and status outputs)
// Signals:
//   start, word_count      : begin a load of word_count words
//   byte_valid, byte_data  : incoming program bytes, big-endian per word
//   byte_ready             : loader accepts a byte this cycle
//   imu_wen/addr/data_in   : instruction memory write port
//   cpu_clr                : holds the processor in clear while high
//   busy, done, err        : load status
interface program_loader_if;
    import mips_pkg::*;

    logic                  start;
    logic [CountWidth-1:0] word_count;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  imu_wen;
    logic [AddrWidth-1:0]  imu_addr;
    logic [WordWidth-1:0]  imu_data_in;
    logic                  cpu_clr;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, imu_wen, imu_addr, imu_data_in, cpu_clr, busy, done, err
    );

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, imu_wen, imu_addr, imu_data_in, cpu_clr, busy, done, err
    );

endinterface

// File: rtl/idle_timer.sv
// Idle-cycle counter for the byte stream.
// Ports:
//   clk     : clock
//   clr     : asynchronous active-low reset
//   restart : clears the count (held while not receiving, pulsed on each accepted byte)
//   expired : count has reached TIMEOUT-1
// The count saturates at TIMEOUT-1 so expired stays high until the next restart.
module idle_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic expired
);

    localparam int unsigned CntWidth = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntWidth-1:0] Limit = CntWidth'(TIMEOUT - 1);

    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = '0;
        end else if (count_q != Limit) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == Limit);

endmodule

// File: rtl/program_loader.sv
// Loads a program from a byte stream into instruction memory while holding the CPU
// in clear. Four bytes (first byte = MSB) form a word, written in a one-cycle WRITE
// state at consecutive word addresses starting at 0x00.
// Ports:
//   clk : clock
//   clr : asynchronous active-low reset
//   bus : program_loader_if.slave (start/word_count, byte stream, imu write port,
//         cpu_clr, busy/done/err)
// Parameters:
//   TIMEOUT   : max idle cycles between accepted bytes while receiving
//   MAX_WORDS : instruction memory depth in words
module program_loader
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned MAX_WORDS = MaxWords
) (
    input  logic                   clk,
    input  logic                   clr,
    program_loader_if.slave        bus
);

    loader_state_e         state_q, state_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [CountWidth-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [WordWidth-1:0]  data_q, data_d;

    // Outputs are registered decodes of the next state, so they line up with state_q.
    logic byte_ready_q, imu_wen_q, cpu_clr_q, busy_q, done_q, err_q;

    logic accept;
    logic timer_restart;
    logic timer_expired;

    assign accept        = bus.byte_valid & byte_ready_q;
    assign timer_restart = (state_q != StRecv) | accept;

    idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .clr     (clr),
        .restart (timer_restart),
        .expired (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            StIdle, StDone, StErr: begin
                if (bus.start) begin
                    count_d    = bus.word_count;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    addr_d     = '0;
                    if (bus.word_count == '0) begin
                        state_d = StDone;
                    end else if (32'(bus.word_count) > MAX_WORDS) begin
                        state_d = StErr;
                    end else begin
                        state_d = StRecv;
                    end
                end
            end
            StRecv: begin
                if (accept) begin
                    case (byte_cnt_q)
                        2'd0:    data_d[31:24] = bus.byte_data;
                        2'd1:    data_d[23:16] = bus.byte_data;
                        2'd2:    data_d[15:8]  = bus.byte_data;
                        default: data_d[7:0]   = bus.byte_data;
                    endcase
                    // Wraps to 0 after the 4th byte, ready for the next word.
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end else if (timer_expired) begin
                    state_d = StErr;
                end
            end
            StWrite: begin
                addr_d     = addr_q + AddrWidth'(4);
                word_cnt_d = word_cnt_q + 1'b1;
                state_d    = (word_cnt_d == count_q) ? StDone : StRecv;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= StIdle;
            count_q      <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            byte_ready_q <= 1'b0;
            imu_wen_q    <= 1'b0;
            cpu_clr_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            byte_ready_q <= (state_d == StRecv);
            imu_wen_q    <= (state_d == StWrite);
            cpu_clr_q    <= (state_d != StDone);
            busy_q       <= (state_d == StRecv) || (state_d == StWrite);
            done_q       <= (state_d == StDone);
            err_q        <= (state_d == StErr);
        end
    end

    assign bus.byte_ready  = byte_ready_q;
    assign bus.imu_wen     = imu_wen_q;
    assign bus.imu_addr    = addr_q;
    assign bus.imu_data_in = data_q;
    assign bus.cpu_clr     = cpu_clr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: max idle cycles between accepted bytes while receiving.
REQ-002 SHALL have parameter MAX_WORDS, default 64: instruction memory depth in words (256 bytes / 4).
REQ-003 SHALL have port clk, input, 1: the single clock, the processor standard clock.
REQ-004 SHALL have port clr, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: single-cycle pulse that begins a load.
REQ-006 SHALL have port word_count, input, 7: number of instruction words to load, sampled on start.
REQ-007 SHALL have port byte_valid, input, 1: byte_data is valid.
REQ-008 SHALL have port byte_data, input, 8: program byte stream, big-endian per word.
REQ-009 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-010 SHALL have port imu_wen, output, 1: instruction memory write-enable.
REQ-011 SHALL have port imu_addr, output, 8: instruction memory byte address.
REQ-012 SHALL have port imu_data_in, output, 32: instruction word to write.
REQ-013 SHALL have port cpu_clr, output, 1: active-high clear that holds PC and register file while high.
REQ-014 SHALL have ports busy, done and err, output, 1 each: load in progress, load completed, load aborted.

Function
REQ-015 SHALL implement FSM states IDLE, RECV, WRITE, DONE, ERR.
REQ-016 IDLE --start--> RECV when 1 <= word_count <= MAX_WORDS; DONE when word_count = 0; ERR when word_count > MAX_WORDS.
REQ-017 start SHALL latch word_count, clear the byte counter (2 bit), clear the word counter, and set the address to 0x00.
REQ-018 A byte SHALL transfer only on a cycle with byte_valid = 1 and byte_ready = 1; byte_ready SHALL be 1 only in RECV.
REQ-019 Byte k of a word (k = 0..3) SHALL load imu_data_in[31-8k -: 8]; the first byte goes to bits [31:24].
REQ-020 The 4th accepted byte SHALL move the FSM RECV -> WRITE; WRITE SHALL last exactly one cycle with imu_wen = 1, holding the current imu_addr and the assembled word.
REQ-021 After WRITE: imu_addr += 4 and word counter += 1; the FSM goes to DONE if word counter = latched count, else to RECV.
REQ-022 imu_addr SHALL step only in multiples of 4; it never wraps, because count <= MAX_WORDS bounds the final address to 0xFC.
REQ-023 An idle counter SHALL reset on every accepted byte and on entry to RECV; reaching TIMEOUT-1 with no transfer in RECV SHALL move the FSM to ERR.
REQ-024 cpu_clr SHALL be 1 in IDLE, RECV, WRITE and ERR, and 0 only in DONE.
REQ-025 busy = 1 in RECV and WRITE; done = 1 in DONE; err = 1 in ERR; all are registered state decodes.
REQ-026 start SHALL be ignored in RECV and WRITE; start in DONE or ERR SHALL behave as in IDLE (reload), and cpu_clr SHALL rise in the following cycle.
REQ-027 A start pulse coinciding with byte_valid SHALL not accept a byte that cycle, because byte_ready is 0 outside RECV.
REQ-028 imu_wen SHALL be 0 in every state except WRITE; a partial word (fewer than 4 bytes) SHALL never be written.
REQ-029 Total latency for N words with back-to-back bytes SHALL be 5N cycles from entry to RECV until done = 1.

Reset
REQ-030 clr = 0 SHALL force, asynchronously: state IDLE, cpu_clr = 1, imu_wen = 0, byte_ready = 0, busy = done = err = 0, imu_addr = 0x00, imu_data_in = 0, and all counters = 0.
REQ-031 Reset mid-load SHALL abandon the load with no further writes; memory contents already written are left as they are.

Structure
REQ-032 A shared package (mips_pkg) SHALL hold the loader state enum type, the memory address width (8), the word width (32) and the MAX_WORDS constant.
REQ-033 The timeout counter SHALL be a sub-module, idle_timer, with ports clk, clr, restart, expired and parameter TIMEOUT.
REQ-034 The loader SHALL drive the instruction memory's wen, addr and data_in directly; multiplexing against the PC-driven address is outside this block.

Verification
REQ-035 word_count = 2, bytes 8C,01,00,04,AC,02,00,08 back-to-back -> writes 0x8C010004 at 0x00 and 0xAC020008 at 0x04; done = 1, cpu_clr = 0, 10 cycles after RECV entry.
REQ-036 word_count = 0 and start -> DONE the next cycle, no imu_wen, cpu_clr = 0.
REQ-037 word_count = 65 -> err = 1, no writes, cpu_clr stays 1.
REQ-038 TIMEOUT = 16, stop after 2 bytes -> err = 1 within 16 cycles, no imu_wen; a new start then loads correctly from 0x00.
REQ-039 clr pulsed low after the 3rd word's WRITE of a 5-word load -> immediately IDLE, cpu_clr = 1, no 4th write; start during RECV is ignored.
REQ-040 byte_valid toggling every other cycle over 1 word -> correct word assembled; each byte accepted only when byte_valid = 1 and byte_ready = 1.
